// File: rtl/cpu02_pkg.sv
// Shared definitions for the cpu02 accumulator core: opcodes, FSM states,
// ALU operation selects and opcode-class helpers.
package cpu02_pkg;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;
    localparam logic [7:0] OP_INC     = 8'h1A;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_AND_IMM = 8'h29;
    localparam logic [7:0] OP_ORA_IMM = 8'h09;
    localparam logic [7:0] OP_EOR_IMM = 8'h49;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_BEQ     = 8'hF0;
    localparam logic [7:0] OP_BNE     = 8'hD0;
    localparam logic [7:0] OP_JMP     = 8'h4C;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_STP     = 8'hDB;

    typedef enum logic [3:0] {
        FETCH, DECODE, OP1A, OP1D, OP2A, OP2D, MEMA, MEMD, MEMW, HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS, ALU_ADC, ALU_AND, ALU_ORA, ALU_EOR, ALU_INC
    } alu_op_e;

    function automatic logic is_imm(input logic [7:0] op);
        return (op == OP_LDA_IMM) || (op == OP_AND_IMM) || (op == OP_ORA_IMM) ||
               (op == OP_EOR_IMM) || (op == OP_ADC_IMM);
    endfunction

    function automatic logic is_branch(input logic [7:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic is_abs(input logic [7:0] op);
        return (op == OP_JMP) || (op == OP_LDA_ABS) || (op == OP_STA_ABS);
    endfunction

    // Anything not otherwise decoded (including unknown opcodes) is a 2-cycle implied op.
    function automatic logic is_implied(input logic [7:0] op);
        return !(is_imm(op) || is_branch(op) || is_abs(op) || (op == OP_STP));
    endfunction

    function automatic alu_op_e imm_alu_op(input logic [7:0] op);
        alu_op_e sel;
        case (op)
            OP_ADC_IMM: sel = ALU_ADC;
            OP_AND_IMM: sel = ALU_AND;
            OP_ORA_IMM: sel = ALU_ORA;
            OP_EOR_IMM: sel = ALU_EOR;
            default:    sel = ALU_PASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cpu02_alu.sv
// Combinational 8-bit ALU for the cpu02 core; carry only changes on ADC,
// zero flag always reflects the result.
module cpu02_alu
    import cpu02_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] operand_i,
    input  logic       c_i,
    input  alu_op_e    op_i,
    output logic [7:0] result_o,
    output logic       c_o,
    output logic       z_o
);

    logic [8:0] sum;

    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, operand_i} + {8'h00, c_i};
        result_o = operand_i;
        c_o      = c_i;
        case (op_i)
            ALU_ADC:  {c_o, result_o} = sum;
            ALU_AND:  result_o = a_i & operand_i;
            ALU_ORA:  result_o = a_i | operand_i;
            ALU_EOR:  result_o = a_i ^ operand_i;
            ALU_INC:  result_o = a_i + 8'd1;
            default:  result_o = operand_i;
        endcase
        z_o = (result_o == 8'h00);
    end

endmodule

// File: rtl/cpu02_core.sv
// Multi-cycle 8-bit accumulator CPU driving the CPU port of a synchronous-read
// video RAM: one memory access per cycle, read data arrives one cycle later.
module cpu02_core
    import cpu02_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        cpu_clk,
    input  logic        reset,
    output logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        wena,
    output logic        halted
);

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  t0_q, t0_d;
    logic [15:0] ea_q, ea_d;
    logic        c_q, c_d;
    logic        z_q, z_d;

    alu_op_e     alu_op;
    logic [7:0]  alu_result;
    logic        alu_c;
    logic        alu_z;
    logic        branch_taken;

    cpu02_alu u_alu (
        .a_i       (a_q),
        .operand_i (data_in),
        .c_i       (c_q),
        .op_i      (alu_op),
        .result_o  (alu_result),
        .c_o       (alu_c),
        .z_o       (alu_z)
    );

    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            a_q     <= 8'h00;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            t0_q    <= 8'h00;
            ea_q    <= 16'h0000;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            t0_q    <= t0_d;
            ea_q    <= ea_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        t0_d         = t0_q;
        ea_d         = ea_q;
        c_d          = c_q;
        z_d          = z_q;
        alu_op       = ALU_PASS;
        branch_taken = (ir_q == OP_BEQ) ? z_q : !z_q;

        case (state_q)
            FETCH: state_d = DECODE;

            // The opcode is only on data_in here; IR is not yet loaded.
            DECODE: begin
                ir_d = data_in;
                pc_d = pc_q + 16'd1;
                if (data_in == OP_STP) begin
                    state_d = HALT;
                end else if (is_implied(data_in)) begin
                    state_d = FETCH;
                    case (data_in)
                        OP_CLC: c_d = 1'b0;
                        OP_SEC: c_d = 1'b1;
                        OP_INC: begin
                            alu_op = ALU_INC;
                            a_d    = alu_result;
                            z_d    = alu_z;
                        end
                        default: ;
                    endcase
                end else begin
                    state_d = OP1A;
                end
            end

            OP1A: state_d = OP1D;

            OP1D: begin
                t0_d    = data_in;
                pc_d    = pc_q + 16'd1;
                state_d = FETCH;
                if (is_imm(ir_q)) begin
                    alu_op = imm_alu_op(ir_q);
                    a_d    = alu_result;
                    z_d    = alu_z;
                    c_d    = alu_c;
                end else if (is_branch(ir_q)) begin
                    if (branch_taken) begin
                        pc_d = pc_q + 16'd1 + {{8{data_in[7]}}, data_in};
                    end
                end else begin
                    state_d = OP2A;
                end
            end

            OP2A: state_d = OP2D;

            OP2D: begin
                ea_d = {data_in, t0_q};
                pc_d = pc_q + 16'd1;
                case (ir_q)
                    OP_JMP: begin
                        pc_d    = {data_in, t0_q};
                        state_d = FETCH;
                    end
                    OP_LDA_ABS: state_d = MEMA;
                    default:    state_d = MEMW;
                endcase
            end

            MEMA: state_d = MEMD;

            MEMD: begin
                alu_op  = ALU_PASS;
                a_d     = alu_result;
                z_d     = alu_z;
                state_d = FETCH;
            end

            MEMW: state_d = FETCH;

            HALT: state_d = HALT;

            default: state_d = FETCH;
        endcase
    end

    // Outputs decode straight from the state register so reset clears wena at once.
    assign addr     = ((state_q == MEMA) || (state_q == MEMW)) ? ea_q : pc_q;
    assign wena     = (state_q == MEMW);
    assign halted   = (state_q == HALT);
    assign data_out = a_q;

endmodule

// File: tb/tb_cpu02_core.sv
// Directed bench for cpu02_core: table of small programs with expected
// results, plus hand-written sequences for reset, jump, wrap and halt cases.
module tb_cpu02_core;
    import cpu02_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  rdata;
    logic [7:0]  data_out;
    logic        wena;
    logic        halted;

    logic [7:0]  mem [0:65535];

    int n_err;
    int n_checks;
    int wcount;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic        fetched78;

    typedef struct packed {
        logic [127:0] prog;
        logic [15:0]  chk_addr;
        logic [7:0]   exp_mem;
        logic [7:0]   exp_a;
        logic         exp_c;
        logic         exp_z;
    } vec_t;

    vec_t vecs [7];

    cpu02_core #(.RESET_PC(16'h0000)) dut (
        .cpu_clk  (clk),
        .reset    (reset),
        .addr     (addr),
        .data_in  (rdata),
        .data_out (data_out),
        .wena     (wena),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM, one cycle latency, read-before-write.
    always @(posedge clk) begin
        rdata <= mem[addr];
        if (wena) mem[addr] = data_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        if (wena) begin
            wcount++;
            waddr = addr;
            wdata = data_out;
        end
        if (dut.state_q == FETCH && (addr == 16'h0007 || addr == 16'h0008))
            fetched78 = 1'b1;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        wcount    = 0;
        waddr     = 16'h0000;
        wdata     = 8'h00;
        fetched78 = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        logic [127:0] p;
        int bad;
        n_err    = 0;
        n_checks = 0;
        reset    = 1'b0;

        vecs[0] = '{prog: 128'hA9_7F_69_01_8D_34_12_00_00_00_00_00_00_00_00_00,
                    chk_addr: 16'h1234, exp_mem: 8'h80, exp_a: 8'h80, exp_c: 1'b0, exp_z: 1'b0};
        vecs[1] = '{prog: 128'h38_A9_FF_69_00_F0_02_EA_EA_1A_8D_00_20_00_00_00,
                    chk_addr: 16'h2000, exp_mem: 8'h01, exp_a: 8'h01, exp_c: 1'b1, exp_z: 1'b0};
        vecs[2] = '{prog: 128'hA9_F0_29_3C_09_01_49_FF_8D_00_30_00_00_00_00_00,
                    chk_addr: 16'h3000, exp_mem: 8'hCE, exp_a: 8'hCE, exp_c: 1'b0, exp_z: 1'b0};
        vecs[3] = '{prog: 128'hA9_55_49_55_D0_02_1A_1A_8D_01_30_00_00_00_00_00,
                    chk_addr: 16'h3001, exp_mem: 8'h02, exp_a: 8'h02, exp_c: 1'b0, exp_z: 1'b0};
        vecs[4] = '{prog: 128'hAD_0A_00_69_01_8D_02_30_00_00_7F_00_00_00_00_00,
                    chk_addr: 16'h3002, exp_mem: 8'h80, exp_a: 8'h80, exp_c: 1'b0, exp_z: 1'b0};
        vecs[5] = '{prog: 128'h18_A9_C8_69_64_8D_03_30_00_00_00_00_00_00_00_00,
                    chk_addr: 16'h3003, exp_mem: 8'h2C, exp_a: 8'h2C, exp_c: 1'b1, exp_z: 1'b0};
        vecs[6] = '{prog: 128'hA9_00_38_F0_01_DB_1A_8D_04_30_00_00_00_00_00_00,
                    chk_addr: 16'h3004, exp_mem: 8'h01, exp_a: 8'h01, exp_c: 1'b1, exp_z: 1'b0};

        // Reset state while held
        clear_mem();
        repeat (4) @(negedge clk);
        check("rst_addr", 32'(addr), 32'h0000);
        check("rst_wena", 32'(wena), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_dout", 32'(data_out), 32'h00);
        reset = 1'b1;
        check("rel_fetch_state", 32'(dut.state_q), 32'(FETCH));
        check("rel_fetch_addr", 32'(addr), 32'h0000);
        cycle();
        check("rel_decode_state", 32'(dut.state_q), 32'(DECODE));

        // Table of programs
        for (int i = 0; i < 7; i++) begin
            clear_mem();
            p = vecs[i].prog;
            for (int k = 0; k < 16; k++) mem[k] = p[127-8*k -: 8];
            do_reset();
            repeat (60) cycle();
            $display("vec %0d: A=%0h C=%0b Z=%0b mem[%0h]=%0h writes=%0d",
                     i, dut.a_q, dut.c_q, dut.z_q, vecs[i].chk_addr, mem[vecs[i].chk_addr], wcount);
            check($sformatf("v%0d_mem", i), 32'(mem[vecs[i].chk_addr]), 32'(vecs[i].exp_mem));
            check($sformatf("v%0d_a", i), 32'(dut.a_q), 32'(vecs[i].exp_a));
            check($sformatf("v%0d_c", i), 32'(dut.c_q), 32'(vecs[i].exp_c));
            check($sformatf("v%0d_z", i), 32'(dut.z_q), 32'(vecs[i].exp_z));
            check($sformatf("v%0d_wcount", i), 32'(wcount), 32'd1);
            check($sformatf("v%0d_waddr", i), 32'(waddr), 32'(vecs[i].chk_addr));
            check($sformatf("v%0d_wdata", i), 32'(wdata), 32'(vecs[i].exp_mem));
            if (i == 1) check("v1_skipped_fetch", 32'(fetched78), 32'h0);
        end

        // JMP timing, then unknown opcode at the target
        clear_mem();
        mem[0] = 8'h4C; mem[1] = 8'h00; mem[2] = 8'h80;
        mem[16'h8000] = 8'hEA; mem[16'h8001] = 8'hEA;
        do_reset();
        repeat (6) cycle();
        $display("jmp: addr=%0h state=%0d", addr, dut.state_q);
        check("jmp_addr", 32'(addr), 32'h8000);
        check("jmp_state", 32'(dut.state_q), 32'(FETCH));
        cycle();
        check("unk_decode", 32'(dut.state_q), 32'(DECODE));
        cycle();
        check("unk_next_addr", 32'(addr), 32'h8001);
        check("unk_next_state", 32'(dut.state_q), 32'(FETCH));

        // PC wrap at 0xFFFF, then BNE-to-self loop at 0x0000
        clear_mem();
        mem[0] = 8'h4C; mem[1] = 8'hFE; mem[2] = 8'hFF;
        mem[16'hFFFE] = 8'hA9; mem[16'hFFFF] = 8'h05;
        do_reset();
        repeat (6) cycle();
        check("wrap_jmp_addr", 32'(addr), 32'hFFFE);
        mem[0] = 8'hD0; mem[1] = 8'hFE; mem[2] = 8'h00;
        repeat (4) cycle();
        $display("wrap: addr=%0h A=%0h", addr, dut.a_q);
        check("wrap_addr", 32'(addr), 32'h0000);
        check("wrap_state", 32'(dut.state_q), 32'(FETCH));
        check("wrap_a", 32'(dut.a_q), 32'h05);
        repeat (2) cycle();
        check("bne_op1a_addr", 32'(addr), 32'h0001);
        repeat (2) cycle();
        check("bne_loop1_addr", 32'(addr), 32'h0000);
        check("bne_loop1_state", 32'(dut.state_q), 32'(FETCH));
        repeat (4) cycle();
        check("bne_loop2_addr", 32'(addr), 32'h0000);
        check("bne_loop2_state", 32'(dut.state_q), 32'(FETCH));

        // STP and halt hold
        clear_mem();
        mem[0] = 8'hA9; mem[1] = 8'h42; mem[2] = 8'hDB;
        do_reset();
        repeat (5) cycle();
        check("stp_decode_halted", 32'(halted), 32'h0);
        cycle();
        check("stp_halted", 32'(halted), 32'h1);
        check("stp_addr", 32'(addr), 32'h0003);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (!halted || wena || addr != 16'h0003) bad++;
        end
        $display("halt: bad cycles=%0d", bad);
        check("halt_hold", 32'(bad), 32'd0);

        // Reset asserted during MEMW
        clear_mem();
        mem[0] = 8'hA9; mem[1] = 8'h77; mem[2] = 8'h8D; mem[3] = 8'h00; mem[4] = 8'h50;
        do_reset();
        repeat (10) cycle();
        check("memw_wena", 32'(wena), 32'h1);
        check("memw_addr", 32'(addr), 32'h5000);
        #1 reset = 1'b0;
        #1;
        $display("abort: wena=%0b addr=%0h dout=%0h", wena, addr, data_out);
        check("abort_wena", 32'(wena), 32'h0);
        check("abort_addr", 32'(addr), 32'h0000);
        check("abort_dout", 32'(data_out), 32'h00);
        repeat (2) cycle();
        check("abort_nowrite", 32'(mem[16'h5000]), 32'h00);
        reset = 1'b1;
        check("restart_state", 32'(dut.state_q), 32'(FETCH));
        cycle();
        check("restart_decode", 32'(dut.state_q), 32'(DECODE));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu02_core.md
Name: cpu02_core

Overview:
- Minimal 8-bit accumulator CPU with a 16-bit address bus.
- Drives the CPU port of the shared video RAM, which is a synchronous-read memory with 1-cycle read latency.
- Multi-cycle, one memory access per cycle, no pipelining.
- Serves as the bring-up processor that writes character codes into VRAM for the video controller.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (first opcode fetch address).

Ports:
- cpu_clk  in  1  CPU clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  out  16  memory address; combinational mux of PC/EA selected by state.
- data_in  in  8  read data from memory; valid the cycle after its address was presented.
- data_out  out  8  write data; always equals A.
- wena  out  1  write enable; high only in state MEMW.
- halted  out  1  high while in state HALT.

Behaviour:
- Reset (asynchronous, active-low) forces the following; reset mid-instruction aborts immediately, with no partial write after reset asserts:
  - A=0, C=0, Z=0, PC=RESET_PC, IR=0, T0=0, EA=0
  - state=FETCH, wena=0, halted=0, data_out=0x00
- Registers: A[7:0], PC[15:0], IR[7:0], T0[7:0], EA[15:0], flags C, Z.
- State machine, one cycle per state:
  - FETCH: addr=PC -> DECODE.
  - DECODE: IR<=data_in; PC<=PC+1.
    - Implied ops execute here -> FETCH.
    - STP -> HALT.
    - All others -> OP1A.
  - OP1A: addr=PC -> OP1D.
  - OP1D: T0<=data_in; PC<=PC+1.
    - Immediate ops execute -> FETCH.
    - Branch taken: PC<=PC+1+sext(data_in), mod 2^16.
    - Abs ops -> OP2A.
  - OP2A: addr=PC -> OP2D.
  - OP2D: EA<={data_in,T0} (little-endian); PC<=PC+1.
    - JMP: PC<={data_in,T0} -> FETCH.
    - LDA abs -> MEMA.
    - STA abs -> MEMW.
  - MEMA: addr=EA -> MEMD.
  - MEMD: A<=data_in, Z updated -> FETCH.
  - MEMW: addr=EA, wena=1, data_out=A -> FETCH.
  - HALT: addr=PC, wena=0, halted=1; exited only by reset.
- Opcodes:
  - 0x00 NOP
  - 0x18 CLC (C=0), 0x38 SEC (C=1)
  - 0x1A INC A (Z updated, C unchanged)
  - 0xA9 LDA #imm, 0x29 AND #imm, 0x09 ORA #imm, 0x49 EOR #imm (Z updated)
  - 0x69 ADC #imm: {C,A}=A+imm+C; Z updated
  - 0xF0 BEQ rel (taken if Z=1), 0xD0 BNE rel (taken if Z=0)
  - 0x4C JMP abs, 0xAD LDA abs, 0x8D STA abs
  - 0xDB STP
  - Any other opcode behaves as NOP (2 cycles).
- Cycle counts:
  - implied: 2
  - immediate/branch: 4
  - JMP: 6
  - STA: 7
  - LDA abs: 8
- Arithmetic and wrap:
  - All arithmetic is mod 256; PC increments wrap 0xFFFF->0x0000.
  - Branch target = address of the byte after the operand, plus sign-extended offset.
  - Flags change only as listed.
- wena is high for exactly one cycle per STA and never during reset or HALT.

Decomposition:
- cpu02_pkg:
  - opcode localparams
  - state enum (FETCH, DECODE, OP1A, OP1D, OP2A, OP2D, MEMA, MEMD, MEMW, HALT)
  - op-class decode helpers: is_implied, is_imm, is_branch, is_abs
- Sub-module cpu02_alu (combinational):
  - inputs: A, operand, C, op select
  - outputs: result, C_out, Z_out
  - covers ADC/AND/ORA/EOR/INC/pass.

Test Plan:
Bench uses a 64 KiB synchronous-read RAM model with 1-cycle latency.
1. Reset: hold reset=0 several cycles -> addr=0x0000, wena=0, halted=0, data_out=0x00. Release -> FETCH at addr 0x0000, DECODE next cycle.
2. Program A9 7F 69 01 8D 34 12 -> exactly one cycle with wena=1, addr=0x1234, data_out=0x80. Afterwards C=0, Z=0, RAM[0x1234]=0x80.
3. Program 38 A9 FF 69 00 F0 02 EA EA 1A -> A=0x00, C=1, Z=1, branch taken skipping both EA bytes, INC gives A=0x01 and Z=0. Never-fetched check: addresses 0x0007/0x0008 never presented in FETCH.
4. Program 4C 00 80 at 0x0000 -> FETCH addr=0x8000 on the 7th cycle after reset release. An unknown opcode 0xEA there advances PC by 1 in 2 cycles.
5. Program at 0xFFFE: A9 05 -> PC wraps to 0x0000. Then D0 FE -> BNE to self loops on 0x0000 (Z=0), addr period 4 cycles.
6. STP -> halted=1 from the following cycle, addr constant, wena=0 for 100 cycles. Separately, assert reset during MEMW -> wena drops immediately (asynchronously) and the core restarts at RESET_PC.
